neuron_mac: RTL and testbench
=============================

# neuron_mac

Multiply-accumulate neuron stage that sits directly downstream of a per-neuron weight ROM. It streams one input activation per valid cycle, reads the matching weight from the ROM, multiplies and accumulates in signed fixed point, and adds the neuron bias. After the last input of a frame it emits one saturated result. One instance pairs with one weight memory; the read port drives the ROM's `ren`/`raddr` and consumes its `wout`.

## Interface
Parameters:
- `numWeight`, 784: inputs (and weights) per frame; must satisfy 2 ≤ numWeight ≤ 2^(addressWidth+1).
- `addressWidth`, 10: ROM address parameter; the address port is addressWidth+1 bits.
- `dataWidth`, 16: width of activations, weights, bias and output (signed two's complement).
- `intWidth`, 4: integer bits including sign; fracBits = dataWidth − intWidth.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_data` carries the next activation of the frame.
- `in_data`  in  dataWidth  signed activation.
- `bias`  in  dataWidth  signed neuron bias, same Q format as data; quasi-static.
- `ren`  out  1  weight ROM read enable.
- `raddr`  out  addressWidth+1  weight ROM read address.
- `wout`  in  dataWidth  weight from ROM, valid one cycle after `ren`.
- `out_valid`  out  1  one-cycle pulse: `out_data` holds the frame result.
- `out_data`  out  dataWidth  saturated neuron pre-activation.

## Operation
- Index counter `idx` (0..numWeight−1) counts accepted inputs. It increments on each `in_valid` and wraps from numWeight−1 to 0. The input with idx = numWeight−1 is marked `last`.
- `ren = in_valid`, `raddr = idx`; both are combinational from the registered counter.
- Stage 1: register `in_data`, a valid bit and `last`, aligned with the ROM's 1-cycle read. On the following edge, register the full-precision signed product `mul_r` = weight × data_d (2·dataWidth bits).
- Stage 2: `sum` = sat(acc + mul_r). The accumulator `acc` is 2·dataWidth signed and adds with saturation to the min/max of that width.
  - Non-last: acc ← sum.
  - Last: acc ← 0. out_data ← sat_dataWidth((sum + (sign-extended bias <<< fracBits)) >>> fracBits), using an arithmetic shift. out_valid ← 1.
- `in_valid` may drop for any number of cycles mid-frame. The valid bits stall nothing and simply carry bubbles; no backpressure exists.
- Back-to-back frames: the first input of frame n+1 may arrive in the cycle after frame n's last input. The clear of acc on `last` guarantees no carry-over.
- Reset (any time, including mid-frame) has these effects:
  - idx, acc and all pipeline valid bits go to 0; the partial frame is discarded.
  - out_valid = 0 and out_data = 0.
  - ren follows in_valid combinationally, and raddr = 0.

## Timing
- Input accepted in cycle t: ROM samples raddr at the end of t; wout is valid in t+1; mul_r is valid in t+2; it is added into acc at the end of t+2.
- Latency: last input in cycle t → out_valid high for exactly cycle t+3. out_data holds its value until the next result.
- Throughput: one input per cycle, one result per numWeight inputs.
- `bias` is sampled at the end of the cycle in which the last product is accumulated (t+2).

## Structure
- Shared package `neuron_pkg`:
  - `fracBits` derivation;
  - saturating-add and saturate-to-width functions, reused by the activation stage.
- Sub-module `sat_acc`: registered saturating accumulator with clear-on-last. The counter, address generation and multiplier pipeline remain in `neuron_mac`.
- The ROM is not instantiated here; it is wired alongside in the layer wrapper.

## Test plan
All scenarios use dataWidth=16, intWidth=4 (1.0 = 0x1000) and numWeight=4, with a behavioural 1-cycle ROM model.
- Weights 0x1000 ×4, inputs 0x0800 ×4 back-to-back, bias 0 → raddr 0,1,2,3; out_data = 0x2000; out_valid only 3 cycles after the 4th input.
- Same frame with bias 0xF000 (−1.0) and in_valid gaps of 0–3 cycles between inputs → out_data = 0x1000; exactly one pulse, 3 cycles after the last input.
- Weights 0x7FFF, inputs 0x7FFF → out_data = 0x7FFF. Weights 0x7FFF, inputs 0x8000 → out_data = 0x8000 (saturation).
- Two frames back-to-back (frame 1 as scenario 1; frame 2 inputs 0x1000, weights 0x1000) → results 0x2000 then 0x4000; raddr wraps 3→0 without a gap.
- Assert rst after 2 inputs, then send a full scenario-1 frame → no out_valid from the partial frame; out_data = 0 during reset; the next result is 0x2000.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared fixed-point helpers for the neuron datapath: Q-format split and
// saturating arithmetic evaluated on a wide signed carrier.
package neuron_pkg;

  localparam int WIDE = 64;
  typedef logic signed [WIDE-1:0] wide_t;

  function automatic int frac_bits(input int dw, input int iw);
    return dw - iw;
  endfunction

  // Clamp v to the signed range of a w-bit two's complement value.
  function automatic wide_t sat_to_width(input wide_t v, input int w);
    wide_t hi, lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
    return sat_to_width(a + b, w);
  endfunction

endpackage

// File: rtl/sat_acc.sv
// Registered saturating accumulator; sum is the combinational saturated
// acc + din, and a clear on the last product restarts the frame at zero.
module sat_acc
  import neuron_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic signed [AW-1:0] din,
  output logic signed [AW-1:0] sum
);

  logic signed [AW-1:0] acc;

  assign sum = AW'(sat_add(wide_t'(acc), wide_t'(din), AW));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     acc <= '0;
    else if (en) acc <= clr ? '0 : sum;
  end

endmodule

// File: rtl/neuron_mac.sv
// Streaming MAC neuron: index/address generation for the weight ROM, a
// two-stage multiply pipeline, saturating accumulation and biased output.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int intWidth     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [dataWidth-1:0] in_data,
  input  logic signed [dataWidth-1:0] bias,
  output logic                        ren,
  output logic [addressWidth:0]       raddr,
  input  logic signed [dataWidth-1:0] wout,
  output logic                        out_valid,
  output logic signed [dataWidth-1:0] out_data
);

  localparam int FB     = frac_bits(dataWidth, intWidth);
  localparam int AW     = 2 * dataWidth;
  localparam int IW     = addressWidth + 1;
  localparam int STAGES = 2;

  logic [IW-1:0]               idx;
  logic                        is_last;
  logic [STAGES-1:0]           vld_pipe, last_pipe;
  logic signed [dataWidth-1:0] data_d;
  logic signed [AW-1:0]        mul_r, sum;

  assign is_last = (idx == IW'(numWeight - 1));
  assign ren     = in_valid;
  assign raddr   = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           idx <= '0;
    else if (in_valid) idx <= is_last ? '0 : idx + 1'b1;
  end

  // [0]: data_d aligned with the ROM read; [1]: mul_r ready to accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      data_d    <= '0;
      mul_r     <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[0], in_valid};
      last_pipe <= {last_pipe[0], in_valid & is_last};
      if (in_valid)    data_d <= in_data;
      if (vld_pipe[0]) mul_r  <= wout * data_d;
    end
  end

  sat_acc #(.AW(AW)) u_acc (
    .clk (clk),
    .rst (rst),
    .en  (vld_pipe[1]),
    .clr (last_pipe[1]),
    .din (mul_r),
    .sum (sum)
  );

  // Bias is aligned to the product's Q format before the fractional bits drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= last_pipe[1];
      if (last_pipe[1])
        out_data <= dataWidth'(sat_to_width(
                      (wide_t'(sum) + (wide_t'(bias) <<< FB)) >>> FB, dataWidth));
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac with a 1-cycle ROM model and a
// plain-arithmetic reference for each frame's result.
module tb_neuron_mac;

  localparam int DW = 16;
  localparam int NW = 4;
  localparam int AWID = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [DW-1:0] bias;
  logic          ren;
  logic [AWID:0] raddr;
  logic [DW-1:0] wout;
  logic          out_valid;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  neuron_mac #(
    .numWeight(NW), .addressWidth(AWID), .dataWidth(DW), .intWidth(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .bias(bias),
    .ren(ren), .raddr(raddr), .wout(wout), .out_valid(out_valid), .out_data(out_data)
  );

  logic [DW-1:0] rom [NW];
  always @(posedge clk) if (ren) wout <= rom[raddr[1:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            ev_cyc [$];
  logic [DW-1:0] ev_dat [$];
  always @(negedge clk) if (out_valid === 1'b1) begin
    ev_cyc.push_back(cyc);
    ev_dat.push_back(out_data);
  end

  int compared = 0;
  int mismatched = 0;

  logic [DW-1:0] fd [NW];
  logic [AWID:0] ga [2*NW];
  logic          gr [2*NW];
  int            last_cyc;

  task automatic drive_frame(input int maxgap, input int base);
    int g;
    for (int i = 0; i < NW; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) begin @(negedge clk); in_valid = 1'b0; end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = fd[i];
      #1;
      ga[base+i] = raddr;
      gr[base+i] = ren;
      last_cyc   = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = DW'($urandom);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] b);
    longint acc, t;
    logic [63:0] r;
    acc = 0;
    for (int i = 0; i < NW; i++) begin
      acc = acc + longint'(signed'(fd[i])) * longint'(signed'(rom[i]));
      if (acc > 64'sd2147483647)  acc = 64'sd2147483647;
      if (acc < -64'sd2147483648) acc = -64'sd2147483648;
    end
    t = (acc + (longint'(signed'(b)) * 4096)) >>> 12;
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    r = 64'(t);
    return r[DW-1:0];
  endfunction

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    compared++; if (out_data !== 16'h0) begin mismatched++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    compared++; if (raddr !== 11'd0) begin mismatched++; $display("FAIL reset_raddr got %0d want 0", raddr); end
    compared++; if (ren !== 1'b1) begin mismatched++; $display("FAIL reset_ren_hi got %b want 1", ren); end
    in_valid = 1'b0;
    #1;
    compared++; if (ren !== 1'b0) begin mismatched++; $display("FAIL reset_ren_lo got %b want 0", ren); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    for (int i = 0; i < NW; i++) begin rom[i] = 16'h1000; fd[i] = 16'h0800; end
    bias = 16'h0000;
    ev_cyc.delete(); ev_dat.delete();
    drive_frame(0, 0);
    idle(6);
    for (int i = 0; i < NW; i++) begin
      compared++; if (ga[i] !== 11'(i) || gr[i] !== 1'b1) begin mismatched++; $display("FAIL basic_raddr[%0d] got %0d ren %b want %0d ren 1", i, ga[i], gr[i], i); end
    end
    compared++; if (ev_cyc.size() !== 1) begin mismatched++; $display("FAIL basic_pulses got %0d want 1", ev_cyc.size()); end
    else begin
      compared++; if (ev_cyc[0] !== last_cyc + 3) begin mismatched++; $display("FAIL basic_latency got %0d want %0d", ev_cyc[0] - last_cyc, 3); end
      compared++; if (ev_dat[0] !== 16'h2000) begin mismatched++; $display("FAIL basic_data got %h want 2000", ev_dat[0]); end
    end
    compared++; if (out_data !== 16'h2000) begin mismatched++; $display("FAIL basic_hold got %h want 2000", out_data); end
  endtask

  task automatic test_gaps;
    bias = 16'hF000;
    for (int r = 0; r < 2; r++) begin
      ev_cyc.delete(); ev_dat.delete();
      drive_frame(3, 0);
      idle(6);
      compared++; if (ev_cyc.size() !== 1) begin mismatched++; $display("FAIL gaps_pulses got %0d want 1", ev_cyc.size()); end
      else begin
        compared++; if (ev_cyc[0] !== last_cyc + 3) begin mismatched++; $display("FAIL gaps_latency got %0d want 3", ev_cyc[0] - last_cyc); end
        compared++; if (ev_dat[0] !== 16'h1000) begin mismatched++; $display("FAIL gaps_data got %h want 1000", ev_dat[0]); end
      end
    end
  endtask

  task automatic test_saturation;
    logic [DW-1:0] din [2];
    logic [DW-1:0] exp [2];
    din[0] = 16'h7FFF; exp[0] = 16'h7FFF;
    din[1] = 16'h8000; exp[1] = 16'h8000;
    bias = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NW; i++) begin rom[i] = 16'h7FFF; fd[i] = din[k]; end
      ev_cyc.delete(); ev_dat.delete();
      drive_frame(0, 0);
      idle(6);
      compared++; if (ev_dat.size() !== 1 || ev_dat[0] !== exp[k]) begin mismatched++; $display("FAIL sat_data[%0d] got %h (%0d pulses) want %h", k, out_data, ev_dat.size(), exp[k]); end
    end
  endtask

  task automatic test_back_to_back;
    int l1;
    for (int i = 0; i < NW; i++) begin rom[i] = 16'h1000; fd[i] = 16'h0800; end
    bias = 16'h0000;
    ev_cyc.delete(); ev_dat.delete();
    drive_frame(0, 0);
    l1 = last_cyc;
    for (int i = 0; i < NW; i++) fd[i] = 16'h1000;
    drive_frame(0, NW);
    idle(6);
    for (int i = 0; i < 2*NW; i++) begin
      compared++; if (ga[i] !== 11'(i % NW)) begin mismatched++; $display("FAIL b2b_raddr[%0d] got %0d want %0d", i, ga[i], i % NW); end
    end
    compared++; if (ev_cyc.size() !== 2) begin mismatched++; $display("FAIL b2b_pulses got %0d want 2", ev_cyc.size()); end
    else begin
      compared++; if (ev_cyc[0] !== l1 + 3 || ev_cyc[1] !== last_cyc + 3) begin mismatched++; $display("FAIL b2b_latency got %0d,%0d want 3,3", ev_cyc[0] - l1, ev_cyc[1] - last_cyc); end
      compared++; if (ev_dat[0] !== 16'h2000 || ev_dat[1] !== 16'h4000) begin mismatched++; $display("FAIL b2b_data got %h,%h want 2000,4000", ev_dat[0], ev_dat[1]); end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < NW; i++) begin rom[i] = 16'h1000; fd[i] = 16'h0800; end
    bias = 16'h0000;
    ev_cyc.delete(); ev_dat.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 16'h7FFF;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    compared++; if (out_data !== 16'h0) begin mismatched++; $display("FAIL midrst_out_data got %h want 0000", out_data); end
    compared++; if (raddr !== 11'd0) begin mismatched++; $display("FAIL midrst_raddr got %0d want 0", raddr); end
    idle(2);
    rst = 1'b0;
    drive_frame(0, 0);
    idle(6);
    for (int i = 0; i < NW; i++) begin
      compared++; if (ga[i] !== 11'(i)) begin mismatched++; $display("FAIL midrst_raddr[%0d] got %0d want %0d", i, ga[i], i); end
    end
    compared++; if (ev_cyc.size() !== 1) begin mismatched++; $display("FAIL midrst_pulses got %0d want 1", ev_cyc.size()); end
    else begin
      compared++; if (ev_cyc[0] !== last_cyc + 3 || ev_dat[0] !== 16'h2000) begin mismatched++; $display("FAIL midrst_result got %h at +%0d want 2000 at +3", ev_dat[0], ev_cyc[0] - last_cyc); end
    end
  endtask

  task automatic test_random;
    logic [DW-1:0] exp;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NW; i++) begin rom[i] = DW'($urandom); fd[i] = DW'($urandom); end
      bias = DW'($urandom);
      exp = model(bias);
      ev_cyc.delete(); ev_dat.delete();
      drive_frame(2, 0);
      idle(5);
      compared++; if (ev_dat.size() !== 1 || ev_dat[0] !== exp || ev_cyc[0] !== last_cyc + 3) begin
        mismatched++; $display("FAIL rand_frame[%0d] got %h (%0d pulses) want %h", f, out_data, ev_dat.size(), exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; bias = '0;
    for (int i = 0; i < NW; i++) rom[i] = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
